gf2_ring_reduce: RTL and testbench

- Sequential reduction stage placed directly downstream of CompleteMultiplier.
- Takes the full 2N-bit GF(2) product W and reduces it into the ring GF(2)[x]/(x^N - 1): R[k] = W[k] ^ W[k+N] for 0 <= k < N.
- Works in WORD-bit chunks, one chunk per cycle, so the XOR/popcount logic stays small.
- Also accumulates the Hamming weight of R for the downstream decoder and flags out-of-range product degree.

---
 rtl/gf2_ring_pkg.sv | 24 ++
 rtl/gf2_popcount_word.sv | 25 ++
 rtl/gf2_ring_reduce.sv | 121 ++++++++++++
 tb/tb_gf2_ring_reduce.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gf2_ring_pkg.sv
// Shared constants and state type for the GF(2) ring reduction stage.
package gf2_ring_pkg;

   // Ring degree (operand width of the upstream multiplier).
   localparam int N         = 17669;
   // Bits folded per cycle.
   localparam int WORD      = 64;

   // Derived sizes.
   localparam int NCHUNK    = (N + WORD - 1) / WORD;
   localparam int LAST_BITS = N - (NCHUNK - 1) * WORD;
   localparam int CNT_W     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int WT_W      = $clog2(N + 1);
   localparam int PC_W      = $clog2(WORD + 1);
   // Wide enough to hold the bit offset of any chunk, (NCHUNK-1)*WORD < N.
   localparam int IDX_W     = $clog2(N);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/gf2_popcount_word.sv
// Combinational population count of one WORD-bit chunk.
module gf2_popcount_word
   import gf2_ring_pkg::*;
#(
   parameter int WIDTH = WORD
) (
   input  logic [WIDTH-1:0]             bits_i,
   output logic [$clog2(WIDTH+1)-1:0]   count_o
);

   localparam int OUT_W = $clog2(WIDTH + 1);

   logic [OUT_W-1:0] sum;

   // Sum the set bits of the chunk.
   always_comb begin
      sum = '0;
      for (int i = 0; i < WIDTH; i++) begin
         sum = sum + OUT_W'(bits_i[i]);
      end
   end

   assign count_o = sum;

endmodule

// File: rtl/gf2_ring_reduce.sv
// Folds a 2N-bit GF(2) product into GF(2)[x]/(x^N - 1), one WORD-bit
// chunk per cycle, accumulating the Hamming weight of the result.
// Handshake: a one-cycle start pulse is accepted only in IDLE or DONE and
// captures W on that edge; start while busy is ignored. done is a level that
// stays high (with R/weight/deg_err stable) until the next accepted start.
module gf2_ring_reduce
   import gf2_ring_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [2*N-1:0]    W,
   output logic [N-1:0]      R,
   output logic [WT_W-1:0]   weight,
   output logic              deg_err,
   output logic              busy,
   output logic              done,
   output state_e            dbg_state
);

   state_e            state_q,   state_d;
   logic [2*N-1:0]    wq_q,      wq_d;
   logic [N-1:0]      r_q,       r_d;
   logic [WT_W-1:0]   weight_q,  weight_d;
   logic              deg_err_q, deg_err_d;
   logic              busy_q,    busy_d;
   logic              done_q,    done_d;
   logic [CNT_W-1:0]  cnt_q,     cnt_d;

   logic [IDX_W-1:0]  base;
   logic              last_chunk;
   logic [WORD-1:0]   lo, hi, mask, f;
   logic [PC_W-1:0]   f_pop;

   // Select the current chunk from both halves and fold them. Shifting the
   // upper half right supplies zeros past 2N-1, so the short last chunk needs
   // only the validity mask to drop positions >= N.
   always_comb begin
      base       = IDX_W'(cnt_q) * IDX_W'(WORD);
      last_chunk = (cnt_q == CNT_W'(NCHUNK - 1));
      lo         = WORD'(wq_q[N-1:0] >> base);
      hi         = WORD'(wq_q[2*N-1:N] >> base);
      mask       = last_chunk ? ({WORD{1'b1}} >> (WORD - LAST_BITS)) : '1;
      f          = (lo ^ hi) & mask;
   end

   gf2_popcount_word #(.WIDTH(WORD)) u_popcount (
      .bits_i  (f),
      .count_o (f_pop)
   );

   // Next-state and datapath update for IDLE / RUN / DONE.
   always_comb begin
      state_d   = state_q;
      wq_d      = wq_q;
      r_d       = r_q;
      weight_d  = weight_q;
      deg_err_d = deg_err_q;
      busy_d    = busy_q;
      done_d    = done_q;
      cnt_d     = cnt_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               wq_d      = W;
               r_d       = '0;
               weight_d  = '0;
               deg_err_d = W[2*N-1];
               cnt_d     = '0;
               busy_d    = 1'b1;
               done_d    = 1'b0;
               state_d   = RUN;
            end
         end
         RUN: begin
            // Overwrite only this chunk's window; bits shifted past N-1 fall off.
            r_d      = (r_q & ~(N'(mask) << base)) | (N'(f) << base);
            weight_d = weight_q + WT_W'(f_pop);
            if (last_chunk) begin
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         wq_q      <= '0;
         r_q       <= '0;
         weight_q  <= '0;
         deg_err_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         wq_q      <= wq_d;
         r_q       <= r_d;
         weight_q  <= weight_d;
         deg_err_q <= deg_err_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         cnt_q     <= cnt_d;
      end
   end

   assign R         = r_q;
   assign weight    = weight_q;
   assign deg_err   = deg_err_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_gf2_ring_reduce.sv
// Self-checking bench for gf2_ring_reduce: a bit-level fold model plus
// hand-computed expectations for the corner polynomials.
module tb_gf2_ring_reduce;
   import gf2_ring_pkg::*;

   // ---------------- clock / reset ----------------
   logic             clk   = 1'b0;
   logic             reset = 1'b0;
   logic             start = 1'b0;
   logic [2*N-1:0]   W     = '0;
   logic [N-1:0]     R;
   logic [WT_W-1:0]  weight;
   logic             deg_err, busy, done;
   state_e           dbg_state;

   always #5 clk = ~clk;

   gf2_ring_reduce dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .W         (W),
      .R         (R),
      .weight    (weight),
      .deg_err   (deg_err),
      .busy      (busy),
      .done      (done),
      .dbg_state (dbg_state)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- reference model ----------------
   function automatic logic [N-1:0] fold(input logic [2*N-1:0] w);
      logic [N-1:0] r;
      for (int k = 0; k < N; k++) r[k] = w[k] ^ w[k+N];
      return r;
   endfunction

   function automatic logic [2*N-1:0] rand_w();
      logic [2*N-1:0] r;
      for (int i = 0; i < 2*N; i++) r[i] = 1'($urandom_range(0, 1));
      return r;
   endfunction

   function automatic logic [255:0] clmul(input logic [127:0] u, input logic [127:0] v);
      logic [255:0] p;
      p = '0;
      for (int i = 0; i < 128; i++)
         if (u[i]) p = p ^ ({128'b0, v} << i);
      return p;
   endfunction

   logic [N-1:0] m_r      = '0;
   int           m_weight = 0;
   logic         m_deg    = 1'b0;
   logic         m_run    = 1'b0;
   logic         m_done   = 1'b0;
   int           m_left   = 0;

   // Model: capture on an accepted start, done after NCHUNK further edges.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_r <= '0; m_weight <= 0; m_deg <= 1'b0;
         m_run <= 1'b0; m_done <= 1'b0; m_left <= 0;
      end else if (start && !m_run) begin
         m_r      <= fold(W);
         m_weight <= $countones(fold(W));
         m_deg    <= W[2*N-1];
         m_run    <= 1'b1;
         m_done   <= 1'b0;
         m_left   <= NCHUNK;
      end else if (m_run) begin
         m_left <= m_left - 1;
         if (m_left == 1) begin
            m_run  <= 1'b0;
            m_done <= 1'b1;
         end
      end
   end

   // ---------------- scoreboard helpers ----------------
   task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_r(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      int first;
      first = -1;
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         for (int i = N - 1; i >= 0; i--) if (act[i] !== exp[i]) first = i;
         $display("FAIL %s: R bit %0d got %b expected %b (popcount got %0d expected %0d)",
                  name, first, act[first], exp[first], $countones(act), $countones(exp));
      end
   endtask

   // Compare process: control outputs every cycle, results whenever not running.
   always @(negedge clk) begin
      check_val("busy", busy, m_run);
      check_val("done", done, m_done);
      check_val("state_run", dbg_state == RUN, m_run);
      check_val("deg_err", deg_err, m_deg);
      if (!m_run) begin
         check_r("model_r", R, m_r);
         check_val("model_weight", weight, m_weight);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_done(output int cyc);
      cyc = 0;
      while (done !== 1'b1 && cyc < 400) begin
         @(negedge clk);
         cyc++;
      end
      if (cyc >= 400) begin
         n_checks++;
         n_fail++;
         $display("FAIL done_timeout: got no done after %0d cycles expected 277", cyc);
      end
   endtask

   task automatic run_job(input logic [2*N-1:0] w, output int cyc);
      @(negedge clk);
      W     = w;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(cyc);
   endtask

   // ---------------- main sequence ----------------
   logic [2*N-1:0] w;
   logic [N-1:0]   e;
   logic [255:0]   p;
   int             cyc;

   initial begin
      #1 reset = 1'b1;
      repeat (3) @(negedge clk);
      check_r("reset_r", R, '0);
      check_val("reset_weight", weight, 0);
      check_val("reset_done", done, 0);
      check_val("reset_busy", busy, 0);
      reset = 1'b0;

      // W = 1 -> R = 1
      w = '0; w[0] = 1'b1;
      run_job(w, cyc);
      check_val("lat_w1", cyc, 277);
      e = '0; e[0] = 1'b1;
      check_r("r_w1", R, e);
      check_val("wt_w1", weight, 1);
      check_val("deg_w1", deg_err, 0);
      check_val("busy_w1", busy, 0);

      // x^N folds onto x^0
      w = '0; w[N] = 1'b1;
      run_job(w, cyc);
      check_r("r_xn", R, e);
      check_val("wt_xn", weight, 1);

      // 1 + x^N cancels
      w = '0; w[0] = 1'b1; w[N] = 1'b1;
      run_job(w, cyc);
      check_r("r_cancel", R, '0);
      check_val("wt_cancel", weight, 0);

      // Last (short) chunk: x^(2N-2) + x^(N-1)
      w = '0; w[2*N-2] = 1'b1; w[N-1] = 1'b1;
      run_job(w, cyc);
      e = '0; e[N-2] = 1'b1; e[N-1] = 1'b1;
      check_r("r_last", R, e);
      check_val("wt_last", weight, 2);
      check_val("deg_last", deg_err, 0);

      // Illegal top bit folds into R[N-1] and raises deg_err
      w = '0; w[2*N-1] = 1'b1;
      run_job(w, cyc);
      e = '0; e[N-1] = 1'b1;
      check_r("r_top", R, e);
      check_val("wt_top", weight, 1);
      check_val("deg_top", deg_err, 1);

      // Outputs hold in DONE
      repeat (20) @(negedge clk);
      check_r("hold_r", R, e);
      check_val("hold_done", done, 1);

      // Random W; W changes at cycle 10, stray start at cycle 50
      w = rand_w();
      @(negedge clk);
      W = w; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (done !== 1'b1 && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (cyc == 10) W = rand_w();
         start = (cyc == 50);
      end
      start = 1'b0;
      check_val("lat_rand", cyc, 277);
      check_r("r_rand", R, fold(w));
      check_val("wt_rand", weight, $countones(fold(w)));
      check_val("deg_rand", deg_err, w[2*N-1]);

      // Asynchronous reset mid-run
      w = rand_w();
      @(negedge clk);
      W = w; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (100) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check_r("async_r", R, '0);
      check_val("async_weight", weight, 0);
      check_val("async_done", done, 0);
      check_val("async_busy", busy, 0);
      @(negedge clk);
      reset = 1'b0;
      w = rand_w();
      run_job(w, cyc);
      check_val("lat_after_reset", cyc, 277);
      check_r("r_after_reset", R, fold(w));
      check_val("wt_after_reset", weight, $countones(fold(w)));

      // End-to-end with a schoolbook carry-less product (degree < N, no wrap)
      p = clmul(128'd4892378128957813477589134, 128'd2398457699321345184592348);
      w = '0; w[255:0] = p;
      run_job(w, cyc);
      check_r("r_e2e", R, N'(p));
      check_val("wt_e2e", weight, $countones(p));
      check_val("deg_e2e", deg_err, 0);

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
